// File: rtl/program_loader_if.sv
// Byte-in / word-out handshake bundle for program_loader; the slave modport is the loader side.
interface program_loader_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [23:0]      instr_data;
  logic             instr_valid;
  logic             instr_ready;
  logic             load_done;
  logic             overflow;
  logic             load_error;
  logic [CNT_W-1:0] word_count;

  modport master (
    output rx_data, rx_valid, instr_ready,
    input  instr_data, instr_valid, load_done, overflow, load_error, word_count
  );

  modport slave (
    input  rx_data, rx_valid, instr_ready,
    output instr_data, instr_valid, load_done, overflow, load_error, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Packs an unstallable byte stream MSB-first into 24-bit words, buffers them in a FIFO and stops after HALT (24'h0) pops;
// word visible 1 cycle after its last byte, full FIFO drops words (sticky overflow); LOADER_CHKSUM_EN adds an XOR checksum byte.
module program_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input logic            clk,
  input logic            reset,
  program_loader_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_B0        = 3'd0,
    S_B1        = 3'd1,
    S_B2        = 3'd2,
    S_HALT_SEEN = 3'd3,
`ifdef LOADER_CHKSUM_EN
    S_CHK       = 3'd4,
`endif
    S_DONE      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         byte_hi_q, byte_hi_d;
  logic [7:0]         byte_mid_q, byte_mid_d;
  logic [23:0]        mem_q [FIFO_DEPTH];
  logic [23:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     occ_q, occ_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               overflow_q, overflow_d;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]         acc_q, acc_d;
  logic               load_error_q, load_error_d;
  logic               halt_popped_q, halt_popped_d;
`endif

  logic        instr_valid;
  logic        load_done;
  logic        take_byte;
  logic        word_cmpl;
  logic        pop;
  logic        push;
  logic        fifo_full;
  logic        halt_pop;
  logic [23:0] new_word;
  logic [23:0] head_word;

  assign head_word = mem_q[rd_ptr_q];
  assign new_word  = {byte_hi_q, byte_mid_q, bus.rx_data};
  assign fifo_full = (occ_q == DEPTH_L);
  assign pop       = instr_valid && bus.instr_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push      = word_cmpl && (!fifo_full || pop);
  // Only HALT can be an all-zero word, and nothing is pushed after it.
  assign halt_pop  = pop && (head_word == 24'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_B0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_B0: if (bus.rx_valid) state_d = S_B1;
      S_B1: if (bus.rx_valid) state_d = S_B2;
      S_B2: if (bus.rx_valid) state_d = (new_word == 24'd0) ? S_HALT_SEEN : S_B0;
`ifdef LOADER_CHKSUM_EN
      S_HALT_SEEN: begin
        if (bus.rx_valid) state_d = (halt_pop || halt_popped_q) ? S_DONE : S_CHK;
      end
      S_CHK: if (halt_pop) state_d = S_DONE;
`else
      S_HALT_SEEN: if (halt_pop) state_d = S_DONE;
`endif
      S_DONE: state_d = S_DONE;
      default: state_d = S_B0;
    endcase
  end

  always_comb begin
    instr_valid = (occ_q != '0) && (state_q != S_DONE);
    load_done   = (state_q == S_DONE);
    take_byte   = bus.rx_valid && ((state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2));
    word_cmpl   = bus.rx_valid && (state_q == S_B2);
  end

  always_comb begin
    byte_hi_d    = byte_hi_q;
    byte_mid_d   = byte_mid_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;

    if (take_byte && (state_q == S_B0)) byte_hi_d  = bus.rx_data;
    if (take_byte && (state_q == S_B1)) byte_mid_d = bus.rx_data;

    if (push) begin
      mem_d[wr_ptr_q] = new_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (word_count_q != {CNT_W{1'b1}}) word_count_d = word_count_q + CNT_W'(1);
    end
    if (word_cmpl && !push) overflow_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

`ifdef LOADER_CHKSUM_EN
  always_comb begin
    acc_d         = acc_q;
    load_error_d  = load_error_q;
    halt_popped_d = halt_popped_q;
    if (take_byte) acc_d = acc_q ^ bus.rx_data;
    // The byte arriving in HALT_SEEN is the checksum; it is compared, never pushed.
    if (bus.rx_valid && (state_q == S_HALT_SEEN) && (bus.rx_data != acc_q)) load_error_d = 1'b1;
    if (halt_pop) halt_popped_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      load_error_q  <= 1'b0;
      halt_popped_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      load_error_q  <= load_error_d;
      halt_popped_q <= halt_popped_d;
    end
  end

  assign bus.load_error = load_error_q;
`else
  assign bus.load_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_hi_q    <= '0;
      byte_mid_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      byte_hi_q    <= byte_hi_d;
      byte_mid_q   <= byte_mid_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.instr_data  = head_word;
  assign bus.instr_valid = instr_valid;
  assign bus.load_done   = load_done;
  assign bus.overflow    = overflow_q;
  assign bus.word_count  = word_count_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a queue-based reference of the byte-to-word loader.
module tb_program_loader;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.CNT_W(CNT_W)) bus ();
  program_loader #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [23:0] m_fifo[$];
  logic [23:0] got[$];
  logic [23:0] m_word;
  int          m_n;
  int          m_wc;
  bit          m_halted, m_halt_popped, m_done, m_ovf, m_err, m_chk_taken;
  logic [7:0]  m_acc;

  function automatic void model_clear();
    m_fifo.delete();
    got.delete();
    m_word = '0; m_n = 0; m_wc = 0; m_acc = '0;
    m_halted = 0; m_halt_popped = 0; m_done = 0; m_ovf = 0; m_err = 0; m_chk_taken = 0;
  endfunction

  // One clock: drive inputs at the falling edge, compare outputs, advance the reference.
  task automatic cycle(input bit v, input logic [7:0] b, input bit r);
    bit exp_valid, pop, full;
    logic [23:0] w;
    @(negedge clk);
    bus.rx_valid = v; bus.rx_data = b; bus.instr_ready = r;
    exp_valid = (m_fifo.size() != 0) && !m_done;
    checks++;
    if (bus.instr_valid !== exp_valid) begin
      failures++; $display("FAIL instr_valid got=%b exp=%b t=%0t", bus.instr_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      checks++;
      if (bus.instr_data !== m_fifo[0]) begin
        failures++; $display("FAIL instr_data got=%h exp=%h t=%0t", bus.instr_data, m_fifo[0], $time);
      end
    end
    checks++;
    if ({bus.overflow, bus.load_done, bus.load_error} !== {m_ovf, m_done, m_err}) begin
      failures++;
      $display("FAIL flags(ovf,done,err) got=%b%b%b exp=%b%b%b t=%0t", bus.overflow, bus.load_done,
               bus.load_error, m_ovf, m_done, m_err, $time);
    end
    checks++;
    if (bus.word_count !== CNT_W'(m_wc)) begin
      failures++; $display("FAIL word_count got=%0d exp=%0d t=%0t", bus.word_count, m_wc, $time);
    end
    if (bus.instr_valid === 1'b1 && r) got.push_back(bus.instr_data);

    pop  = exp_valid && r;
    full = (m_fifo.size() == DEPTH);
    if (pop) begin
      w = m_fifo.pop_front();
      if (m_halted && w == 24'd0) m_halt_popped = 1;
    end
    if (v && !m_halted) begin
      m_acc  = m_acc ^ b;
      m_word = {m_word[15:0], b};
      m_n++;
      if (m_n == 3) begin
        if (!full || pop) begin
          m_fifo.push_back(m_word);
          if (m_wc < (1 << CNT_W) - 1) m_wc++;
        end else begin
          m_ovf = 1;
        end
        if (m_word == 24'd0) m_halted = 1;
        m_n = 0;
      end
    end
`ifdef LOADER_CHKSUM_EN
    else if (v && !m_chk_taken) begin
      m_chk_taken = 1;
      if (b != m_acc) m_err = 1;
    end
    m_done = m_halt_popped && m_chk_taken;
`else
    m_done = m_halt_popped;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.instr_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic send_word(input logic [23:0] w, input bit r, input bit gaps);
    for (int k = 2; k >= 0; k--) begin
      if (gaps) repeat ($urandom_range(0, 1)) cycle(1'b0, 8'h00, r);
      cycle(1'b1, w[k*8 +: 8], r);
    end
  endtask

  // HALT plus, when enabled, the matching checksum byte.
  task automatic send_halt(input logic [7:0] chk_xor);
    send_word(24'h000000, 1'b1, 1'b0);
`ifdef LOADER_CHKSUM_EN
    cycle(1'b1, m_acc ^ chk_xor, 1'b1);
`else
    if (chk_xor != 0) cycle(1'b0, 8'h00, 1'b1);
`endif
  endtask

  task automatic drain(input int target);
    for (int i = 0; i < 40 && got.size() < target; i++) cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (got.size() != target) begin
      failures++; $display("FAIL drain_count got=%0d exp=%0d", got.size(), target);
    end
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    w = 24'($urandom);
    if (w == 24'd0) w = 24'h000001;
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if ({bus.instr_valid, bus.load_done, bus.overflow, bus.load_error, bus.word_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b/%0d exp=0000/0", bus.instr_valid, bus.load_done,
               bus.overflow, bus.load_error, bus.word_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_word(24'h020105, 1'b1, 1'b0);
    send_halt(8'h00);
    drain(2);
    checks++;
    if (got.size() != 2 || got[0] !== 24'h020105 || got[1] !== 24'h000000) begin
      failures++; $display("FAIL basic_words got_n=%0d exp=020105,000000", got.size());
    end
    checks++;
    if (bus.load_done !== 1'b1 || bus.word_count !== CNT_W'(2)) begin
      failures++; $display("FAIL basic_done got=%b/%0d exp=1/2", bus.load_done, bus.word_count);
    end
  endtask

  task automatic test_after_done();
    cycle(1'b1, 8'h0E, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.word_count !== CNT_W'(2) || bus.load_done !== 1'b1) begin
      failures++;
      $display("FAIL after_done got=%b/%0d/%b exp=0/2/1", bus.instr_valid, bus.word_count, bus.load_done);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] words[9];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      words[i] = rand_word();
      send_word(words[i], 1'b0, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.word_count !== CNT_W'(8)) begin
      failures++; $display("FAIL overflow_state got=%b/%0d exp=1/8", bus.overflow, bus.word_count);
    end
    drain(8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== words[i]) begin
        failures++; $display("FAIL overflow_order idx=%0d got=%h exp=%h", i, got[i], words[i]);
      end
    end
  endtask

  task automatic test_midword_reset();
    do_reset();
    cycle(1'b1, 8'h06, 1'b1);
    cycle(1'b1, 8'h02, 1'b1);
    do_reset();
    send_word(24'h070102, 1'b1, 1'b0);
    send_halt(8'h00);
    drain(2);
    checks++;
    if (got.size() == 0 || got[0] !== 24'h070102) begin
      failures++; $display("FAIL midword_first got=%h exp=070102", (got.size() != 0) ? got[0] : 24'hx);
    end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] last;
    do_reset();
    for (int i = 0; i < 8; i++) send_word(rand_word(), 1'b0, 1'b0);
    last = rand_word();
    cycle(1'b1, last[23:16], 1'b0);
    cycle(1'b1, last[15:8], 1'b0);
    cycle(1'b1, last[7:0], 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0 || bus.word_count !== CNT_W'(9) || bus.instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop got=%b/%0d/%b exp=0/9/1", bus.overflow, bus.word_count, bus.instr_valid);
    end
    drain(9);
    checks++;
    if (got.size() != 9 || got[got.size()-1] !== last) begin
      failures++; $display("FAIL full_push_pop_tail got_n=%0d exp_last=%h", got.size(), last);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) send_word(rand_word(), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.word_count !== {CNT_W{1'b1}} || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL saturation got=%0d/%b exp=255/0", bus.word_count, bus.overflow);
    end
  endtask

  task automatic test_random();
    logic [23:0] w;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      w = rand_word();
      for (int k = 2; k >= 0; k--) begin
        repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        cycle(1'b1, w[k*8 +: 8], 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);
    send_halt(8'h00);
    for (int i = 0; i < 20 && !m_done; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.load_done !== 1'b1) begin
      failures++; $display("FAIL random_done got=%b exp=1", bus.load_done);
    end
  endtask

`ifdef LOADER_CHKSUM_EN
  task automatic test_chksum();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      send_word(24'h010000, 1'b1, 1'b0);
      send_word(24'h000000, 1'b1, 1'b0);
      cycle(1'b1, (pass == 0) ? 8'h01 : 8'h00, 1'b1);
      drain(2);
      checks++;
      if (bus.load_done !== 1'b1 || bus.load_error !== 1'(pass)) begin
        failures++;
        $display("FAIL chksum pass=%0d got=%b/%b exp=1/%0d", pass, bus.load_done, bus.load_error, pass);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.instr_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_after_done();
    test_overflow();
    test_midword_reset();
    test_full_push_pop();
    test_saturation();
    test_random();
`ifdef LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
